cordic_div_seq: RTL and testbench

- Parametrised, handshaked, iterative CORDIC divider in linear-vectoring mode.
- Computes q = y / x in signed fixed point, INT_W integer bits and FRAC_W fraction bits; one shift-add iteration per cycle.
- Successor to the FPU's fixed Q8.24 CORDIC divider; adds reset, valid/ready handshakes, signed-divisor handling, divide-by-zero and range flags, and configurable width and iteration count.
- Sits in the FPU mantissa datapath, fed by the operand-unpack stage.

---
 rtl/cordic_pkg.sv | 34 +++
 rtl/cordic_lin_step.sv | 33 +++
 rtl/cordic_div_seq.sv | 146 ++++++++++++++
 tb/tb_cordic_div_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared state type, default widths and fixed-point helpers for the CORDIC divider family.
package cordic_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam int unsigned INT_W_DEF  = 8;
    localparam int unsigned FRAC_W_DEF = 24;
    localparam int unsigned W_DEF      = INT_W_DEF + FRAC_W_DEF;
    localparam int unsigned YW_DEF     = W_DEF + 2;
    localparam int unsigned ZW_DEF     = W_DEF + 1;

    function automatic logic signed [63:0] one_val(input int unsigned frac_w);
        return 64'sd1 <<< frac_w;
    endfunction

    // Optionally negate v, then clamp into a w-bit signed range (-MIN maps to MAX).
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] v,
                                                   input logic              neg,
                                                   input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = neg ? -v : v;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_lin_step.sv
// One linear-vectoring CORDIC iteration: drives the residual y toward zero, accumulating z.
module cordic_lin_step import cordic_pkg::*; #(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned YW     = YW_DEF,
    parameter int unsigned ZW     = ZW_DEF,
    parameter int unsigned IW     = 5
) (
    input  logic signed [YW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [YW-1:0] xa_i,
    input  logic        [IW-1:0] idx_i,
    output logic signed [YW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    localparam logic [ZW-1:0] One = ZW'(one_val(FRAC_W));

    logic [YW-1:0] y_step;
    logic [ZW-1:0] z_step;

    always_comb begin
        y_step = xa_i >> idx_i;
        z_step = One >> idx_i;
        if (y_i[YW-1]) begin
            y_o = y_i + y_step;
            z_o = z_i - z_step;
        end else begin
            y_o = y_i - y_step;
            z_o = z_i + z_step;
        end
    end

endmodule

// File: rtl/cordic_div_seq.sv
// Handshaked iterative CORDIC divider, q = y / x in signed fixed point.
// Define CORDIC_DIV_SAT_EN to saturate the quotient on divide-by-zero / range errors.
module cordic_div_seq import cordic_pkg::*; #(
    parameter int unsigned INT_W  = INT_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ITER   = FRAC_W + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [INT_W+FRAC_W-1:0] y_i,
    input  logic [INT_W+FRAC_W-1:0] x_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [INT_W+FRAC_W-1:0] quot_o,
    output logic                    div_zero_o,
    output logic                    range_err_o
);

    localparam int unsigned W  = INT_W + FRAC_W;
    localparam int unsigned YW = W + 2;
    localparam int unsigned ZW = W + 1;
    localparam int unsigned IW = $clog2(ITER + 1);

    state_e               state_q;
    logic signed [YW-1:0] y_q;
    logic signed [YW-1:0] y_nx;
    logic signed [YW-1:0] y_ext;
    logic signed [YW-1:0] x_ext;
    logic signed [ZW-1:0] z_q;
    logic signed [ZW-1:0] z_nx;
    logic signed [ZW-1:0] z_fin;
    logic        [YW-1:0] xa_q;
    logic        [YW-1:0] ya;
    logic        [YW-1:0] xa;
    logic        [IW-1:0] i_q;
    logic                 neg_q;
    logic                 neg_in;
    logic        [W-1:0]  flag_quot;
    logic        [W-1:0]  run_quot;

    cordic_lin_step #(
        .FRAC_W(FRAC_W),
        .YW    (YW),
        .ZW    (ZW),
        .IW    (IW)
    ) u_step (
        .y_i  (y_q),
        .z_i  (z_q),
        .xa_i (xa_q),
        .idx_i(i_q),
        .y_o  (y_nx),
        .z_o  (z_nx)
    );

    always_comb begin
        y_ext  = {{2{y_i[W-1]}}, y_i};
        x_ext  = {{2{x_i[W-1]}}, x_i};
        ya     = y_ext[YW-1] ? -y_ext : y_ext;
        xa     = x_ext[YW-1] ? -x_ext : x_ext;
        neg_in = x_i[W-1] ^ y_i[W-1];
        // Early exit keeps the current z; the last iteration uses the stepped z.
        z_fin    = (y_q == '0) ? z_q : z_nx;
        run_quot = W'(sat_neg(64'(z_fin), neg_q, W));
`ifdef CORDIC_DIV_SAT_EN
        if (y_i == '0) begin
            flag_quot = '0;
        end else begin
            flag_quot = neg_in ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`else
        flag_quot = '0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            quot_o      <= '0;
            div_zero_o  <= 1'b0;
            range_err_o <= 1'b0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            xa_q        <= '0;
            neg_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        // Iterate on magnitudes; the sign is reapplied from neg_q at the end.
                        xa_q    <= xa;
                        neg_q   <= neg_in;
                        y_q     <= ya;
                        z_q     <= '0;
                        i_q     <= '0;
                        ready_o <= 1'b0;
                        if (x_i == '0) begin
                            state_q    <= StDone;
                            valid_o    <= 1'b1;
                            div_zero_o <= 1'b1;
                            quot_o     <= flag_quot;
                        end else if (ya >= (xa << 1)) begin
                            state_q     <= StDone;
                            valid_o     <= 1'b1;
                            range_err_o <= 1'b1;
                            quot_o      <= flag_quot;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (y_q == '0) begin
                        state_q <= StDone;
                        valid_o <= 1'b1;
                        quot_o  <= run_quot;
                    end else begin
                        y_q <= y_nx;
                        z_q <= z_nx;
                        i_q <= i_q + 1'b1;
                        if (i_q == IW'(ITER - 1)) begin
                            state_q <= StDone;
                            valid_o <= 1'b1;
                            quot_o  <= run_quot;
                        end
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        state_q     <= StIdle;
                        ready_o     <= 1'b1;
                        valid_o     <= 1'b0;
                        div_zero_o  <= 1'b0;
                        range_err_o <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_div_seq.sv
// Self-checking bench for cordic_div_seq: vector table, handshake/reset corners, random operands.
module tb_cordic_div_seq;

    localparam int unsigned INT_W    = 8;
    localparam int unsigned FRAC_W   = 24;
    localparam int unsigned ITER     = FRAC_W + 1;
    localparam int unsigned W        = INT_W + FRAC_W;
    localparam int          MAX_LAT  = ITER + 1;
    localparam int          MAX_WAIT = 60;
    localparam logic [31:0] QMAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN     = 32'h8000_0000;
`ifdef CORDIC_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] y_i;
    logic [W-1:0] x_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] quot_o;
    logic         div_zero_o;
    logic         range_err_o;

    int total;
    int bad;

    cordic_div_seq #(
        .INT_W (INT_W),
        .FRAC_W(FRAC_W),
        .ITER  (ITER)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .y_i        (y_i),
        .x_i        (x_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .quot_o     (quot_o),
        .div_zero_o (div_zero_o),
        .range_err_o(range_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] y;
        logic [31:0] x;
        logic [31:0] q;
        bit          dz;
        bit          re;
        int          lat;
    } vec_t;

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Quotient reported when a flag is raised.
    function automatic logic [31:0] flag_q(input logic [31:0] y, input logic [31:0] x);
        if (!SAT || y == 32'd0) return 32'd0;
        return (y[31] ^ x[31]) ? QMIN : QMAX;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Accept if q*x is within 2 LSB*|x| of y, i.e. |q - y/x| <= 2 LSB.
    task automatic check_quot(input string name, input logic [31:0] y, input logic [31:0] x,
                              input logic [31:0] q);
        longint yl;
        longint xl;
        longint ql;
        longint err;
        yl  = $signed(y);
        xl  = $signed(x);
        ql  = $signed(q);
        err = labs(ql * xl - (yl <<< FRAC_W));
        total++;
        if (err > 2 * labs(xl)) begin
            bad++;
            $display("FAIL %s: quot %08h expected about %08h (+-2 LSB)", name, q,
                     32'((yl <<< FRAC_W) / xl));
        end
    endtask

    task automatic check_bound(input string name, input int got, input int limit);
        total++;
        if (got > limit) begin
            bad++;
            $display("FAIL %s: latency %0d exceeds %0d", name, got, limit);
        end
    endtask

    // Issue one division; optionally complete the result handshake.
    task automatic run_op(input logic [31:0] y, input logic [31:0] x, input bit release_res,
                          output logic [31:0] q, output bit dz, output bit re,
                          output int lat, output bit ok);
        int n;
        @(negedge clk_i);
        y_i     = y;
        x_i     = x;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < MAX_WAIT) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat <= MAX_WAIT) begin
            @(negedge clk_i);
            lat++;
        end
        ok = valid_o;
        q  = quot_o;
        dz = div_zero_o;
        re = range_err_o;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: valid_o absent after %0d cycles (y=%08h x=%08h)", lat, y, x);
        end else if (release_res) begin
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
            check("idle ready_o", longint'(ready_o), 1);
            check("idle valid_o", longint'(valid_o), 0);
        end
    endtask

    vec_t        vecs[10];
    logic [31:0] q;
    logic [31:0] q0;
    bit          dz;
    bit          re;
    bit          ok;
    bit          seen;
    int          lat;

    initial begin
        total   = 0;
        bad     = 0;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        y_i     = '0;
        x_i     = '0;

        vecs[0] = '{32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 1'b0, 1'b0, 0};
        vecs[1] = '{32'hFF40_0000, 32'h0100_0000, 32'hFF40_0000, 1'b0, 1'b0, 0};
        vecs[2] = '{32'h00C0_0000, 32'hFF00_0000, 32'hFF40_0000, 1'b0, 1'b0, 0};
        vecs[3] = '{32'h0100_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1};
        vecs[4] = '{32'h0300_0000, 32'h0100_0000, 32'h0, 1'b0, 1'b1, 1};
        vecs[5] = '{32'hFF00_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0100_0000, 1'b0, 1'b0, 0};
        vecs[8] = '{32'hFE00_0000, 32'h0100_0000, 32'h0, 1'b0, 1'b1, 1};
        vecs[9] = '{32'h0000_0000, 32'h0100_0000, 32'h0, 1'b0, 1'b0, 2};
        for (int j = 0; j < 10; j++) begin
            if (vecs[j].dz || vecs[j].re) vecs[j].q = flag_q(vecs[j].y, vecs[j].x);
        end

        repeat (3) @(negedge clk_i);
        check("reset ready_o", longint'(ready_o), 1);
        check("reset valid_o", longint'(valid_o), 0);
        check("reset quot_o", longint'(quot_o), 0);
        check("reset div_zero_o", longint'(div_zero_o), 0);
        check("reset range_err_o", longint'(range_err_o), 0);
        rst_ni = 1'b1;

        for (int j = 0; j < 10; j++) begin
            run_op(vecs[j].y, vecs[j].x, 1'b1, q, dz, re, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d div_zero_o", j), longint'(dz), longint'(vecs[j].dz));
                check($sformatf("vec%0d range_err_o", j), longint'(re), longint'(vecs[j].re));
                if (vecs[j].dz || vecs[j].re)
                    check($sformatf("vec%0d quot_o", j), longint'(q), longint'(vecs[j].q));
                else
                    check_quot($sformatf("vec%0d quot_o", j), vecs[j].y, vecs[j].x, q);
                if (vecs[j].lat != 0)
                    check($sformatf("vec%0d latency", j), longint'(lat), longint'(vecs[j].lat));
                else
                    check_bound($sformatf("vec%0d latency", j), lat, MAX_LAT);
            end
        end

        // Back-pressure: result held, new requests ignored while busy.
        run_op(32'h0100_0000, 32'h0200_0000, 1'b0, q0, dz, re, lat, ok);
        check_quot("hold first quot", 32'h0100_0000, 32'h0200_0000, q0);
        y_i     = 32'h0300_0000;
        x_i     = 32'h0;
        valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("hold quot_o", longint'(quot_o), longint'(q0));
            check("hold valid_o", longint'(valid_o), 1);
            check("hold ready_o", longint'(ready_o), 0);
            check("hold div_zero_o", longint'(div_zero_o), 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("release ready_o", longint'(ready_o), 1);
        check("release valid_o", longint'(valid_o), 0);
        @(negedge clk_i);
        check("ignored request valid_o", longint'(valid_o), 0);

        // Reset in the middle of an iteration sequence.
        @(negedge clk_i);
        y_i     = 32'h0100_0000;
        x_i     = 32'h0300_0000;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("abort ready_o", longint'(ready_o), 1);
        check("abort valid_o", longint'(valid_o), 0);
        check("abort quot_o", longint'(quot_o), 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        check("abort no result", longint'(seen), 0);
        run_op(32'h0100_0000, 32'h0300_0000, 1'b1, q, dz, re, lat, ok);
        if (ok) check_quot("post-reset quot", 32'h0100_0000, 32'h0300_0000, q);

        for (int k = 0; k < 40; k++) begin
            longint      ax;
            longint      ay;
            longint      xl;
            longint      yl;
            longint      lim;
            logic [31:0] xv;
            logic [31:0] yv;
            bit          exp_re;
            if ($urandom_range(1, 0) == 0)
                ax = longint'($urandom_range(128, 1)) <<< FRAC_W;
            else
                ax = longint'($urandom_range(32'h7FFF_FFFF, 32'h4000_0000));
            xl = ($urandom_range(1, 0) == 1 || ax == (64'sd1 <<< 31)) ? -ax : ax;
            xv = xl[31:0];
            if ($urandom_range(3, 0) == 0) begin
                yv = $urandom;
            end else begin
                lim = (2 * ax < 64'sd2147483647) ? 2 * ax : 64'sd2147483647;
                ay  = longint'($urandom) % lim;
                yl  = ($urandom_range(1, 0) == 1) ? -ay : ay;
                yv  = yl[31:0];
            end
            yl     = $signed(yv);
            exp_re = labs(yl) >= 2 * ax;
            run_op(yv, xv, 1'b1, q, dz, re, lat, ok);
            if (ok) begin
                check($sformatf("rnd%0d div_zero_o", k), longint'(dz), 0);
                check($sformatf("rnd%0d range_err_o", k), longint'(re), longint'(exp_re));
                if (exp_re)
                    check($sformatf("rnd%0d quot_o", k), longint'(q), longint'(flag_q(yv, xv)));
                else
                    check_quot($sformatf("rnd%0d quot_o", k), yv, xv, q);
                check_bound($sformatf("rnd%0d latency", k), lat, MAX_LAT);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
